// File: rtl/radix5_out_serializer_pkg.sv
// Shared definitions for the radix-5 butterfly output path: bin count, index width
// and the complex-word type used between stages.
package radix5_out_serializer_pkg;

    localparam int RADIX      = 5;
    localparam int IDX_W      = 3;
    localparam int DW_DEFAULT = 32;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] re;
        logic [DW_DEFAULT-1:0] img;
    } cplx_t;

    // Bin index advance with wrap after the last bin of a frame.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(RADIX - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/radix5_frame_bank.sv
// One frame of RADIX complex words: parallel write of the whole frame, indexed read.
module radix5_frame_bank
    import radix5_out_serializer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_re  [RADIX],
    input  logic [DW-1:0]    wr_img [RADIX],
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_re,
    output logic [DW-1:0]    rd_img
);

    logic [DW-1:0] re_q  [RADIX];
    logic [DW-1:0] img_q [RADIX];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RADIX; k++) begin
                re_q[k]  <= '0;
                img_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < RADIX; k++) begin
                re_q[k]  <= wr_re[k];
                img_q[k] <= wr_img[k];
            end
        end
    end

    always_comb begin
        rd_re  = '0;
        rd_img = '0;
        for (int k = 0; k < RADIX; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_re  = re_q[k];
                rd_img = img_q[k];
            end
        end
    end

endmodule

// File: rtl/radix5_out_serializer.sv
// Captures one parallel radix-5 frame per accepted cycle into a ping-pong store and
// streams it out one complex sample per cycle, bins 0..4, over valid/ready.
module radix5_out_serializer
    import radix5_out_serializer_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NBUF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    a_re,
    input  logic [DW-1:0]    a_img,
    input  logic [DW-1:0]    b_re,
    input  logic [DW-1:0]    b_img,
    input  logic [DW-1:0]    c_re,
    input  logic [DW-1:0]    c_img,
    input  logic [DW-1:0]    d_re,
    input  logic [DW-1:0]    d_img,
    input  logic [DW-1:0]    e_re,
    input  logic [DW-1:0]    e_img,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_img,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    localparam logic [1:0] FULL_CNT = 2'(NBUF);

    logic [1:0]       count;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] idx;

    logic [DW-1:0] frm_re  [RADIX];
    logic [DW-1:0] frm_img [RADIX];
    logic [DW-1:0] bank_re  [2];
    logic [DW-1:0] bank_img [2];

    logic wr_fire;
    logic rd_fire;
    logic release_bank;

    assign frm_re[0]  = a_re;  assign frm_img[0] = a_img;
    assign frm_re[1]  = b_re;  assign frm_img[1] = b_img;
    assign frm_re[2]  = c_re;  assign frm_img[2] = c_img;
    assign frm_re[3]  = d_re;  assign frm_img[3] = d_img;
    assign frm_re[4]  = e_re;  assign frm_img[4] = e_img;

    // Both handshake qualifiers come from registered count only.
    assign in_ready     = (count != FULL_CNT);
    assign out_valid    = (count != 2'd0);
    assign wr_fire      = in_valid && in_ready;
    assign rd_fire      = out_valid && out_ready;
    assign release_bank = rd_fire && (idx == IDX_W'(RADIX - 1));

    for (genvar g = 0; g < 2; g++) begin : g_bank
        radix5_frame_bank #(.DW(DW)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_fire && (wr_bank == 1'(g))),
            .wr_re  (frm_re),
            .wr_img (frm_img),
            .rd_idx (idx),
            .rd_re  (bank_re[g]),
            .rd_img (bank_img[g])
        );
    end

    assign out_re   = rd_bank ? bank_re[1]  : bank_re[0];
    assign out_img  = rd_bank ? bank_img[1] : bank_img[0];
    assign out_idx  = idx;
    assign out_last = out_valid && (idx == IDX_W'(RADIX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            idx     <= '0;
        end else begin
            if (wr_fire)
                wr_bank <= ~wr_bank;
            if (rd_fire)
                idx <= next_idx(idx);
            if (release_bank)
                rd_bank <= ~rd_bank;
            // A write and a release in the same cycle leave count unchanged.
            case ({wr_fire, release_bank})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_radix5_out_serializer.sv
// Directed bench for radix5_out_serializer with hand-computed expected samples.
module tb_radix5_out_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_re, a_img, b_re, b_img, c_re, c_img, d_re, d_img, e_re, e_img;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_img;
    logic [2:0]  out_idx;
    logic        out_last;

    int tests = 0;
    int fails = 0;

    radix5_out_serializer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img),
        .c_re(c_re), .c_img(c_img), .d_re(d_re), .d_img(d_img),
        .e_re(e_re), .e_img(e_img),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_img(out_img),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame pattern: bin k carries re = r0 + k, img = i0 * (k + 1).
    task automatic set_frame(input int r0, input int i0);
        a_re = 32'(r0);     a_img = 32'(i0);
        b_re = 32'(r0 + 1); b_img = 32'(i0 * 2);
        c_re = 32'(r0 + 2); c_img = 32'(i0 * 3);
        d_re = 32'(r0 + 3); d_img = 32'(i0 * 4);
        e_re = 32'(r0 + 4); e_img = 32'(i0 * 5);
    endtask

    task automatic chk_sample(input string tag, input int r0, input int i0, input int k);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_re"},    out_re,  32'(r0 + k));
        chk({tag, "_img"},   out_img, 32'(i0 * (k + 1)));
        chk({tag, "_idx"},   32'(out_idx), 32'(k));
        chk({tag, "_last"},  32'(out_last), (k == 4) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic pat [9];
        int   b;
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_frame(0, 0);
        repeat (3) tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_out_idx", 32'(out_idx), 32'd0);
            chk("idle_out_last", 32'(out_last), 32'd0);
        end

        // Single frame, out_ready held high
        set_frame(1, 10); in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_sample("single", 1, 10, k);
            tick();
        end
        chk("single_done_valid", 32'(out_valid), 32'd0);

        // Three back-to-back frames into a stalled output
        out_ready = 1'b0;
        set_frame(100, 1000); in_valid = 1'b1;
        chk("burst_f0_ready", 32'(in_ready), 32'd1);
        tick();
        set_frame(200, 2000);
        chk("burst_f1_ready", 32'(in_ready), 32'd1);
        tick();
        set_frame(300, 3000);
        chk("burst_f2_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk_sample("burst_hold", 100, 1000, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_sample("burst_f0", 100, 1000, k);
            chk("burst_f0_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            chk_sample("burst_f1", 200, 2000, k);
            chk("burst_f1_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        chk("burst_done_valid", 32'(out_valid), 32'd0);

        // Irregular downstream stalls on one frame
        out_ready = 1'b0;
        set_frame(7, 70); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        b = 0;
        for (int i = 0; i < 9; i++) begin
            out_ready = pat[i];
            chk_sample("stall", 7, 70, b);
            tick();
            if (pat[i]) b++;
        end
        chk("stall_xfers", 32'(b), 32'd5);
        chk("stall_done_valid", 32'(out_valid), 32'd0);

        // Write coinciding with release of the read bank
        out_ready = 1'b1;
        set_frame(11, 110); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_sample("simul_f0", 11, 110, k);
            tick();
        end
        set_frame(21, 210); in_valid = 1'b1;
        chk("simul_in_ready", 32'(in_ready), 32'd1);
        chk_sample("simul_f0", 11, 110, 4);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_sample("simul_f1", 21, 210, k);
            chk("simul_f1_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        chk("simul_done_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a frame with a second frame buffered
        out_ready = 1'b0;
        set_frame(31, 310); in_valid = 1'b1;
        tick();
        set_frame(41, 410);
        tick();
        in_valid = 1'b0;
        chk("rstmid_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk_sample("rstmid_f0", 31, 310, k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out_idx", 32'(out_idx), 32'd0);
        chk("rstmid_out_last", 32'(out_last), 32'd0);
        tick();
        chk("rstmid_still_empty", 32'(out_valid), 32'd0);
        set_frame(51, 510); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_sample("rstmid_new", 51, 510, k);
            tick();
        end
        chk("rstmid_done_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
